// File: rtl/cpu_display_scanner.sv
// rtl/cpu_display_scanner.sv - button-stepped hex viewer for cpu r0..r7/IR/PC on a 4-digit 7-seg display
// Optional auto-advance of the selected source: CPU_DISPLAY_AUTO_CYCLE_EN
module cpu_display_scanner #(
  parameter int SCAN_DIV        = 50000,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_DIV        = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] r0,
  input  logic [15:0] r1,
  input  logic [15:0] r2,
  input  logic [15:0] r3,
  input  logic [15:0] r4,
  input  logic [15:0] r5,
  input  logic [15:0] r6,
  input  logic [15:0] r7,
  input  logic [15:0] IR,
  input  logic [15:0] PC,
  input  logic        btn_up,
  input  logic        btn_dn,
  input  logic        hold,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic [9:0]  sel_led
);

  localparam logic [15:0] SCAN_MAX = 16'(SCAN_DIV - 1);
  localparam logic [19:0] DB_MAX   = 20'(DEBOUNCE_CYCLES - 1);

  // bit 0 = up button, bit 1 = down button
  logic [1:0]  sync1_q, sync2_q;
  logic [1:0]  stable_q, stable_d, prev_q;
  logic [19:0] db_cnt_q [2];
  logic [19:0] db_cnt_d [2];
  logic        up_p, dn_p;

  logic [3:0]  src_sel_q, src_sel_d;
  logic        chg_q;
  logic [9:0]  sel_led_q, sel_led_d;
  logic [15:0] presc_q, presc_d;
  logic        tick;
  logic [1:0]  digit_q, digit_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] src_val;
  logic [3:0]  nib;
  logic [3:0]  an_q, an_d;
  logic [6:0]  seg_q, seg_d;
  logic        auto_adv;

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      stable_d[i] = stable_q[i];
      db_cnt_d[i] = '0;
      if (sync2_q[i] != stable_q[i]) begin
        if (db_cnt_q[i] == DB_MAX) stable_d[i] = sync2_q[i];
        else                       db_cnt_d[i] = db_cnt_q[i] + 20'd1;
      end
    end
  end

  assign up_p = stable_q[0] & ~prev_q[0];
  assign dn_p = stable_q[1] & ~prev_q[1];

`ifdef CPU_DISPLAY_AUTO_CYCLE_EN
  localparam logic [26:0] AUTO_MAX = 27'(AUTO_DIV - 1);
  logic [26:0] auto_cnt_q, auto_cnt_d;
  logic        auto_wrap;

  assign auto_wrap = (auto_cnt_q == AUTO_MAX);
  assign auto_adv  = auto_wrap & ~hold & ~up_p & ~dn_p;

  always_comb begin
    auto_cnt_d = auto_cnt_q + 27'd1;
    if (up_p || dn_p || auto_wrap) auto_cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) auto_cnt_q <= '0;
    else     auto_cnt_q <= auto_cnt_d;
  end
`else
  localparam logic [31:0] AUTO_DIV_BITS = AUTO_DIV;
  logic unused_auto_div;
  assign unused_auto_div = ^AUTO_DIV_BITS;
  assign auto_adv        = 1'b0;
`endif

  // Simultaneous up/down pulses cancel; a button pulse always beats auto-advance.
  always_comb begin
    src_sel_d = src_sel_q;
    if (up_p && !dn_p)      src_sel_d = (src_sel_q == 4'd9) ? 4'd0 : src_sel_q + 4'd1;
    else if (dn_p && !up_p) src_sel_d = (src_sel_q == 4'd0) ? 4'd9 : src_sel_q - 4'd1;
    else if (auto_adv)      src_sel_d = (src_sel_q == 4'd9) ? 4'd0 : src_sel_q + 4'd1;
  end

  always_comb begin
    case (src_sel_q)
      4'd0:    src_val = r0;
      4'd1:    src_val = r1;
      4'd2:    src_val = r2;
      4'd3:    src_val = r3;
      4'd4:    src_val = r4;
      4'd5:    src_val = r5;
      4'd6:    src_val = r6;
      4'd7:    src_val = r7;
      4'd8:    src_val = IR;
      4'd9:    src_val = PC;
      default: src_val = 16'h0000;
    endcase
  end

  assign tick      = (presc_q == SCAN_MAX);
  assign presc_d   = tick ? 16'd0 : presc_q + 16'd1;
  assign digit_d   = tick ? digit_q + 2'd1 : digit_q;
  assign sel_led_d = 10'd1 << src_sel_q;

  // Frame-boundary loads keep all four digits from one snapshot; hold only blocks those.
  always_comb begin
    shadow_d = shadow_q;
    if (chg_q || (tick && digit_q == 2'd3 && !hold)) shadow_d = src_val;
  end

  always_comb begin
    case (digit_q)
      2'd0:    nib = shadow_q[3:0];
      2'd1:    nib = shadow_q[7:4];
      2'd2:    nib = shadow_q[11:8];
      default: nib = shadow_q[15:12];
    endcase
  end

  always_comb begin
    an_d = ~(4'b0001 << digit_q);
    case (nib)
      4'h0:    seg_d = 7'b1000000;
      4'h1:    seg_d = 7'b1111001;
      4'h2:    seg_d = 7'b0100100;
      4'h3:    seg_d = 7'b0110000;
      4'h4:    seg_d = 7'b0011001;
      4'h5:    seg_d = 7'b0010010;
      4'h6:    seg_d = 7'b0000010;
      4'h7:    seg_d = 7'b1111000;
      4'h8:    seg_d = 7'b0000000;
      4'h9:    seg_d = 7'b0010000;
      4'hA:    seg_d = 7'b0001000;
      4'hB:    seg_d = 7'b0000011;
      4'hC:    seg_d = 7'b1000110;
      4'hD:    seg_d = 7'b0100001;
      4'hE:    seg_d = 7'b0000110;
      default: seg_d = 7'b0001110;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q     <= '0;
      sync2_q     <= '0;
      stable_q    <= '0;
      prev_q      <= '0;
      db_cnt_q[0] <= '0;
      db_cnt_q[1] <= '0;
      src_sel_q   <= '0;
      chg_q       <= 1'b0;
      sel_led_q   <= 10'b0000000001;
      presc_q     <= '0;
      digit_q     <= '0;
      shadow_q    <= '0;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
    end else begin
      sync1_q     <= {btn_dn, btn_up};
      sync2_q     <= sync1_q;
      stable_q    <= stable_d;
      prev_q      <= stable_q;
      db_cnt_q[0] <= db_cnt_d[0];
      db_cnt_q[1] <= db_cnt_d[1];
      src_sel_q   <= src_sel_d;
      chg_q       <= (src_sel_d != src_sel_q);
      sel_led_q   <= sel_led_d;
      presc_q     <= presc_d;
      digit_q     <= digit_d;
      shadow_q    <= shadow_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign seg     = seg_q;
  assign an      = an_q;
  assign sel_led = sel_led_q;

endmodule

// File: tb/tb_cpu_display_scanner.sv
// tb/tb_cpu_display_scanner.sv - self-checking bench for cpu_display_scanner (SCAN_DIV=4, DEBOUNCE_CYCLES=3)
module tb_cpu_display_scanner;

  localparam int S = 4;
  localparam int D = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] r0, r1, r2, r3, r4, r5, r6, r7, IR, PC;
  logic        btn_up = 1'b0, btn_dn = 1'b0, hold = 1'b0;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic [9:0]  sel_led;

  int n_checks = 0;
  int n_fail   = 0;

  cpu_display_scanner #(.SCAN_DIV(S), .DEBOUNCE_CYCLES(D), .AUTO_DIV(20)) dut (
    .clk(clk), .rst(rst),
    .r0(r0), .r1(r1), .r2(r2), .r3(r3), .r4(r4), .r5(r5), .r6(r6), .r7(r7),
    .IR(IR), .PC(PC),
    .btn_up(btn_up), .btn_dn(btn_dn), .hold(hold),
    .seg(seg), .an(an), .sel_led(sel_led)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] hexseg(input logic [3:0] v);
    case (v)
      4'h0: return 7'b1000000;  4'h1: return 7'b1111001;
      4'h2: return 7'b0100100;  4'h3: return 7'b0110000;
      4'h4: return 7'b0011001;  4'h5: return 7'b0010010;
      4'h6: return 7'b0000010;  4'h7: return 7'b1111000;
      4'h8: return 7'b0000000;  4'h9: return 7'b0010000;
      4'hA: return 7'b0001000;  4'hB: return 7'b0000011;
      4'hC: return 7'b1000110;  4'hD: return 7'b0100001;
      4'hE: return 7'b0000110;  default: return 7'b0001110;
    endcase
  endfunction

  function automatic logic [15:0] srcval(input logic [3:0] s);
    case (s)
      4'd0: return r0;  4'd1: return r1;  4'd2: return r2;  4'd3: return r3;
      4'd4: return r4;  4'd5: return r5;  4'd6: return r6;  4'd7: return r7;
      4'd8: return IR;  4'd9: return PC;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: k counts edges since reset; raw samples are kept so a press is judged
  // as "D consecutive synchronized samples at the new level".
  int          k;
  bit          m_valid = 1'b0;
  logic [3:0]  m_sel, ns;
  bit          m_chg, m_stb_up, m_stb_dn, m_p_up, m_p_dn, fu, fd;
  logic [15:0] m_shadow, tmp;
  bit          h_up [64];
  bit          h_dn [64];
  int          dg;
  logic [3:0]  e_an;
  logic [6:0]  e_seg;
  logic [9:0]  e_led;

  function automatic bit flips(input bit stb, input int kk, input bit is_up);
    for (int j = kk - D - 1; j <= kk - 2; j++) begin
      bit v;
      v = (j >= 1) ? (is_up ? h_up[j % 64] : h_dn[j % 64]) : 1'b0;
      if (v == stb) return 1'b0;
    end
    return 1'b1;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      k = 0; m_sel = 4'd0; m_chg = 1'b0; m_shadow = 16'h0;
      m_stb_up = 1'b0; m_stb_dn = 1'b0; m_p_up = 1'b0; m_p_dn = 1'b0;
      e_an = 4'b1111; e_seg = 7'b1111111; e_led = 10'b0000000001;
      m_valid = 1'b1;
    end else begin
      k++;
      dg    = ((k - 1) / S) % 4;
      e_an  = ~(4'b0001 << dg);
      tmp   = m_shadow >> (4 * dg);
      e_seg = hexseg(tmp[3:0]);
      e_led = 10'd1 << m_sel;
      if (m_chg || ((k % (4 * S)) == 0 && !hold)) m_shadow = srcval(m_sel);
      ns = m_sel;
      if (m_p_up && !m_p_dn)      ns = (m_sel == 4'd9) ? 4'd0 : m_sel + 4'd1;
      else if (m_p_dn && !m_p_up) ns = (m_sel == 4'd0) ? 4'd9 : m_sel - 4'd1;
      m_chg = (ns != m_sel);
      m_sel = ns;
      h_up[k % 64] = btn_up;
      h_dn[k % 64] = btn_dn;
      fu = flips(m_stb_up, k, 1'b1);
      fd = flips(m_stb_dn, k, 1'b0);
      m_p_up = fu && !m_stb_up;
      m_p_dn = fd && !m_stb_dn;
      if (fu) m_stb_up = !m_stb_up;
      if (fd) m_stb_dn = !m_stb_dn;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      chk("model_an", {28'd0, an}, {28'd0, e_an});
      chk("model_seg", {25'd0, seg}, {25'd0, e_seg});
      chk("model_sel_led", {22'd0, sel_led}, {22'd0, e_led});
    end
  end

  task automatic press(input bit u, input bit d, input int n);
    @(negedge clk);
    btn_up = u; btn_dn = d;
    repeat (n) @(negedge clk);
    btn_up = 1'b0; btn_dn = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic wait_an(input logic [3:0] v, input int budget);
    int c = 0;
    while (an !== v && c < budget) begin
      @(negedge clk);
      c++;
    end
    if (an !== v) chk("wait_an_timeout", {28'd0, an}, {28'd0, v});
  endtask

  task automatic lit(input string name, input logic [3:0] ean, input logic [6:0] eseg);
    chk({name, "_an"}, {28'd0, an}, {28'd0, ean});
    chk({name, "_seg"}, {25'd0, seg}, {25'd0, eseg});
  endtask

  initial begin
    r0 = 16'h1234; r1 = 16'hABCD; r2 = 16'h2468; r3 = 16'h1357;
    r4 = 16'hFEDC; r5 = 16'h0F0F; r6 = 16'h8421; r7 = 16'h7E57;
    IR = 16'hC0DE; PC = 16'h9A5F;

    repeat (3) @(negedge clk);
    lit("reset", 4'b1111, 7'b1111111);
    chk("reset_sel_led", {22'd0, sel_led}, 32'd1);
    rst = 1'b0;

    @(negedge clk);
    lit("frame0_d0", 4'b1110, 7'b1000000);
    repeat (16) @(negedge clk);
    lit("frame1_d0", 4'b1110, 7'b0011001);
    repeat (4) @(negedge clk);
    lit("frame1_d1", 4'b1101, 7'b0110000);

    press(1'b1, 1'b0, 10);
    chk("up_sel_led", {22'd0, sel_led}, {22'd0, 10'b0000000010});
    wait_an(4'b1110, 20);
    lit("r1_d0", 4'b1110, 7'b0100001);
    repeat (4) @(negedge clk);
    lit("r1_d1", 4'b1101, 7'b1000110);
    repeat (4) @(negedge clk);
    lit("r1_d2", 4'b1011, 7'b0000011);
    repeat (4) @(negedge clk);
    lit("r1_d3", 4'b0111, 7'b0001000);

    press(1'b1, 1'b0, 2);
    chk("glitch_sel_led", {22'd0, sel_led}, {22'd0, 10'b0000000010});

    press(1'b0, 1'b1, 10);
    press(1'b0, 1'b1, 10);
    chk("dn_wrap_sel_led", {22'd0, sel_led}, {22'd0, 10'b1000000000});
    wait_an(4'b1110, 20);
    lit("pc_d0", 4'b1110, 7'b0001110);
    press(1'b1, 1'b0, 10);
    chk("up_wrap_sel_led", {22'd0, sel_led}, 32'd1);
    for (int i = 0; i < 10; i++) press(1'b1, 1'b0, 10);
    chk("ten_up_sel_led", {22'd0, sel_led}, 32'd1);

    @(negedge clk);
    hold = 1'b1;
    r0 = 16'h5678;
    repeat (40) @(negedge clk);
    wait_an(4'b0111, 20);
    lit("hold_d3", 4'b0111, 7'b1111001);
    hold = 1'b0;
    repeat (20) @(negedge clk);
    wait_an(4'b0111, 20);
    lit("unhold_d3", 4'b0111, 7'b0010010);

    hold = 1'b1;
    press(1'b1, 1'b0, 10);
    wait_an(4'b1110, 20);
    lit("hold_sel_d0", 4'b1110, 7'b0100001);
    hold = 1'b0;

    press(1'b1, 1'b1, 10);
    chk("both_sel_led", {22'd0, sel_led}, {22'd0, 10'b0000000010});

    @(negedge clk);
    btn_up = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("midreset_sel_led", {22'd0, sel_led}, 32'd1);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    btn_up = 1'b0;
    repeat (12) @(negedge clk);
    chk("post_reset_press_sel_led", {22'd0, sel_led}, {22'd0, 10'b0000000010});

    repeat (8) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
